// File: rtl/exc_pkg.sv
// Shared types and constants for the multi-source exception unit.
// EXC_VECTORED_EN selects per-cause handler vectors.
package exc_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } exc_state_t;

  localparam logic [1:0] SEL_ELR  = 2'b00;
  localparam logic [1:0] SEL_ESR  = 2'b01;
  localparam logic [1:0] SEL_EFAR = 2'b10;

  localparam int unsigned VEC_STRIDE = 'h80;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: bit 0 wins.
// Combinational; valid when any request is set.
module exc_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0]         req,
  output logic                    valid,
  output logic [$clog2(NSRC)-1:0] cause
);

  localparam int CW = $clog2(NSRC);

  always_comb begin
    valid = |req;
    cause = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) cause = CW'(i);
    end
  end

endmodule

// File: rtl/exception_unit_nsrc.sv
// LEGv8 multi-source exception controller with ERET.
// Define EXC_VECTORED_EN for per-cause handler vectors.
module exception_unit_nsrc
  import exc_pkg::*;
#(
  parameter int            N        = 64,
  parameter int            NSRC     = 4,
  parameter logic [N-1:0]  VEC_BASE = 'h0D8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] exc_req,
  input  logic [NSRC-1:0] exc_mask,
  input  logic            eret,
  input  logic [N-1:0]    next_pc,
  input  logic [N-1:0]    imem_addr,
  input  logic [N-1:0]    alu_branch,
  input  logic [1:0]      edata_sel,
  output logic            eproc,
  output logic [N-1:0]    ev_addr,
  output logic [N-1:0]    pc_branch,
  output logic [N-1:0]    read_data,
  output logic            exc_ack,
  output logic            in_handler
);

  localparam int CW = $clog2(NSRC);

  exc_state_t      state;
  logic [N-1:0]    elr;
  logic [N-1:0]    esr;
  logic [N-1:0]    efar;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] req_live;
  logic [NSRC-1:0] req_eff;
  logic            req_any;
  logic [CW-1:0]   cause;
  logic            take;

  assign req_live = exc_req & ~exc_mask;
  assign req_eff  = (exc_req | pending) & ~exc_mask;

  exc_prio_enc #(
    .NSRC (NSRC)
  ) u_enc (
    .req   (req_eff),
    .valid (req_any),
    .cause (cause)
  );

  assign take       = (state == IDLE) && req_any;
  assign eproc      = take;
  assign in_handler = (state == HANDLER);

  // losers of a take stay pending so they follow the return
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      elr     <= '0;
      esr     <= '0;
      efar    <= '0;
      pending <= '0;
      exc_ack <= 1'b0;
    end else begin
      exc_ack <= take;
      unique case (state)
        IDLE: begin
          if (take) begin
            elr     <= next_pc;
            efar    <= imem_addr;
            esr     <= N'(cause);
            pending <= (pending | req_live)
                     & ~(NSRC'(1) << cause);
            state   <= HANDLER;
          end
        end
        HANDLER: begin
          pending <= pending | req_live;
          if (eret) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXC_VECTORED_EN
  assign ev_addr = VEC_BASE
                 + N'(cause) * N'(VEC_STRIDE);
`else
  assign ev_addr = VEC_BASE;
`endif

  assign pc_branch = (in_handler && eret)
                   ? elr : alu_branch;

  always_comb begin
    read_data = '0;
    case (edata_sel)
      SEL_ELR:  read_data = elr;
      SEL_ESR:  read_data = esr;
      SEL_EFAR: read_data = efar;
      default:  read_data = '0;
    endcase
  end

endmodule
